window_linebuffer: RTL and testbench
====================================

# window_linebuffer

Streaming 9x9 window generator that sits directly upstream of the per-class inner-product stages. It accepts a raster-order pixel stream of 7-bit grey values and buffers the previous eight image rows in line memories. For every pixel that completes a full 9x9 neighbourhood inside the image, it presents that neighbourhood as an 81-entry window array with a one-cycle valid pulse. The window array is fanned out unchanged to all inner-product instances.

## Interface
- IMG_W, 28: image width in pixels; must be ≥ 9.
- IMG_H, 28: image height in pixels; must be ≥ 9.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in  in  7  input pixel, unsigned.
- pix_valid  in  1  pix_in is accepted on this edge. There is no back-pressure.
- sof  in  1  start of frame; qualified by pix_valid; marks the pixel as (row 0, col 0).
- window  out  7 x [0:80]  window array; index = r*9 + c. r=0 is the oldest (top) row, c=0 is the oldest (left) column, window[80] is the newest pixel.
- win_valid  out  1  one-cycle pulse when window holds a new complete in-image neighbourhood.

## Operation
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel being accepted.
  - On an accepted pixel with sof=1, that pixel is position (0,0); the counters then advance from there.
  - Otherwise the pixel takes the current counter value.
  - col increments on each accepted pixel. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0, so the next frame starts implicitly without sof.
- Eight line memories L0..L7, each IMG_W deep and 7 bits wide. L0 holds the previous row, L7 the row eight above.
  - On an accepted pixel at column col: read all eight lines at address col.
  - In the same cycle, write pix_in into L0[col] and write Lk[col] (old value) into L(k+1)[col].
  - Each memory is read-before-write at the same address.
- Window shift register: on an accepted pixel, each row shifts left by one column (c ← c+1).
  - The new column c=8 is loaded top to bottom with L7[col], L6[col], …, L0[col], pix_in.
- win_valid is set to 1 on the edge after an accepted pixel with row ≥ 8 and col ≥ 8; otherwise it is 0.
  - Windows never straddle a row boundary or a frame boundary.
- Windows per frame: (IMG_W-8)*(IMG_H-8).
- Cycles with no accepted pixel: window, counters and memories hold; win_valid is 0.
- Line memory contents are not reset. Stale data is never exposed, because valid gating requires eight fresh rows after a reset or an sof resync.

## Timing
- Latency: the pixel accepted at edge N appears as window[80] after edge N; win_valid is high during cycle N+1 only.
- Sustained throughput is one pixel per clock.
- Reset values: win_valid=0, every window entry=0, row=0, col=0.
- Reset asserted mid-frame: all of the above clear immediately. The first win_valid after release follows the acceptance of pixel (8,8).
- sof on a pixel that is not at (0,0): the frame restarts at that pixel. No windows are produced until the new (8,8).
- sof exactly at the natural wrap: no effect beyond the normal wrap.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H).

## Configuration
- LB_COORD_EN defined: adds two outputs, win_row (width $clog2(IMG_H)) and win_col (width $clog2(IMG_W)).
  - They hold the bottom-right coordinates of the current window and update together with window.
  - Reset value is 0.
- LB_COORD_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Shared package lb_pkg:
  - PIX_W=7, WIN=9, WIN_AREA=81, NUM_LINES=8.
  - typedef pix_t (logic [PIX_W-1:0]).
  - typedef win_t (pix_t array [0:WIN_AREA-1]).
- Sub-module lb_line_mem: one IMG_W-deep, read-before-write line memory with a single shared address. It is instantiated NUM_LINES times and chained.

## Test plan
- IMG_W=IMG_H=12, pixel value = (row*12+col) mod 128, streamed continuously. Required:
  - exactly 16 win_valid pulses;
  - the first pulse is one cycle after pixel 104 is accepted, with window[0]=0, window[8]=8, window[72]=96, window[80]=104;
  - the last pulse has window[80]=143 mod 128=15.
- Same frame with a random idle cycle (pix_valid=0) after every pixel: same 16 windows with identical contents; window is held and win_valid stays 0 during idle cycles.
- Two back-to-back frames without sof: no window pulses from frame-1 row 11 until frame-2 pixel (8,8). Frame-2 windows match frame 1.
- sof asserted at frame-1 pixel (5,3): counters restart; the next win_valid comes 104 accepted pixels later, with window[80] equal to the 105th pixel after the resync.
- rst_n pulsed low at pixel (10,10): win_valid and window read 0 immediately and stay 0 until pixel (8,8) of the restarted stream.
- With LB_COORD_EN: the first window reports win_row=8, win_col=8 and the last reports 11,11. Without it, the build elaborates with no coordinate ports.

Source files
------------

// File: rtl/lb_pkg.sv
// lb_pkg: constants and types shared by the window line buffer and the
// inner-product stages that consume its window.
//
//   PIX_W     width of one grey pixel
//   WIN       window edge length (9x9 neighbourhood)
//   WIN_AREA  number of entries in one window
//   NUM_LINES number of buffered previous rows
//   pix_t     one pixel
//   win_t     one window, indexed r*WIN + c (r=0 top/oldest, c=0 left/oldest)
package lb_pkg;

  localparam int PIX_W     = 7;
  localparam int WIN       = 9;
  localparam int WIN_AREA  = WIN * WIN;
  localparam int NUM_LINES = WIN - 1;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t win_t [0:WIN_AREA-1];

  // Flat window index of row r, column c.
  function automatic int win_idx(input int r, input int c);
    return r * WIN + c;
  endfunction

endpackage

// File: rtl/lb_line_mem.sv
// lb_line_mem: one image row of pixel storage with a single shared address.
// The read is combinational from the current contents, so a write to the
// same address on the same edge returns the old value (read-before-write).
// Contents are deliberately not reset.
//
// Ports:
//   clk      clock
//   wr_en    write rd address with wr_data on the rising edge
//   addr     shared read/write column address
//   wr_data  pixel to store
//   rd_data  pixel currently stored at addr
module lb_line_mem
  import lb_pkg::*;
#(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [PIX_W-1:0]  rd_data
);

  pix_t mem_q [0:DEPTH-1];

  assign rd_data = mem_q[addr];

  // Plain storage array: no reset, valid gating upstream hides stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_linebuffer.sv
// window_linebuffer: streaming 9x9 window generator.
// Accepts a raster-order pixel stream, keeps the previous eight rows in a
// chain of line memories and presents every fully in-image 9x9 neighbourhood
// as an 81-entry window with a one-cycle valid pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   pix_in     input pixel
//   pix_valid  pixel accepted on this edge (no back-pressure)
//   sof        start of frame, qualified by pix_valid; pixel is (0,0)
//   window     current window, index r*9+c, window[80] is the newest pixel
//   win_valid  one-cycle pulse when window holds a new complete neighbourhood
//   win_row    (LB_COORD_EN only) bottom row of the current window
//   win_col    (LB_COORD_EN only) right column of the current window
//
// Configuration macro: LB_COORD_EN adds the win_row/win_col outputs.
module window_linebuffer
  import lb_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output win_t                     window,
  output logic                     win_valid
`ifdef LB_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(WIN - 1);

  logic [COL_W-1:0] col_q, col_d, pos_col;
  logic [ROW_W-1:0] row_q, row_d, pos_row;
  logic             win_valid_q, win_valid_d;
  win_t             window_q, window_d;
  pix_t             line_rd [NUM_LINES];
  pix_t             line_wr [NUM_LINES];

  // Position of the pixel being accepted: sof forces it to (0,0),
  // otherwise it is the running counter value.
  always_comb begin
    pos_col = col_q;
    pos_row = row_q;
    if (sof) begin
      pos_col = '0;
      pos_row = '0;
    end
  end

  // Counters advance from the accepted position; the wrap at the last
  // pixel of the frame starts the next frame without needing sof.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  // Line chain: the new pixel enters L0 and each line hands its old value
  // at this column one line further up.
  always_comb begin
    line_wr[0] = pix_in;
    for (int k = 1; k < NUM_LINES; k++) begin
      line_wr[k] = line_rd[k-1];
    end
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    lb_line_mem #(
      .DEPTH (IMG_W)
    ) u_mem (
      .clk     (clk),
      .wr_en   (pix_valid),
      .addr    (pos_col),
      .wr_data (line_wr[k]),
      .rd_data (line_rd[k])
    );
  end

  // Window shift: every row moves one column left and the new right column
  // is filled top to bottom with L7..L0 followed by the incoming pixel.
  always_comb begin
    window_d    = window_q;
    win_valid_d = 1'b0;
    if (pix_valid) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          window_d[win_idx(r, c)] = window_q[win_idx(r, c + 1)];
        end
      end
      for (int r = 0; r < NUM_LINES; r++) begin
        window_d[win_idx(r, WIN - 1)] = line_rd[NUM_LINES - 1 - r];
      end
      window_d[WIN_AREA - 1] = pix_in;
      win_valid_d = (pos_row >= ROW_FULL) && (pos_col >= COL_FULL);
    end
  end

  // State registers; line memories are intentionally outside the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < WIN_AREA; i++) begin
        window_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      window_q    <= window_d;
    end
  end

  assign window    = window_q;
  assign win_valid = win_valid_q;

`ifdef LB_COORD_EN
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  // Coordinates follow the window: they move on every accepted pixel.
  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (pix_valid) begin
      win_row_d = pos_row;
      win_col_d = pos_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

endmodule

// File: tb/tb_window_linebuffer.sv
// tb_window_linebuffer: scoreboard bench for window_linebuffer on a 12x12
// image. The stimulus side keeps its own copy of the image and queues the
// expected window (with the cycle it is due) for every pixel that completes
// a neighbourhood; a negedge monitor pops and compares on each win_valid.
module tb_window_linebuffer;
  import lb_pkg::*;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             sof = 1'b0;
  win_t             window;
  logic             win_valid;
`ifdef LB_COORD_EN
  logic [RW-1:0]    win_row;
  logic [CW-1:0]    win_col;
`endif

  always #5 clk = ~clk;

  window_linebuffer #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .window    (window),
    .win_valid (win_valid)
`ifdef LB_COORD_EN
    ,
    .win_row   (win_row),
    .win_col   (win_col)
`endif
  );

  typedef struct {
    logic [WIN_AREA-1:0][PIX_W-1:0] w;
    int row;
    int col;
    int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   first_cyc = 0;
  win_t first_win;
  win_t last_win;
  int   first_row, first_col, last_row, last_col;

  logic [PIX_W-1:0] img [0:H-1][0:W-1];
  int   m_row = 0;
  int   m_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle; the model tracks position and queues expected windows.
  task automatic applyStimulus(input int pix, input bit s, input bit v);
    exp_t e;
    pix_in    = PIX_W'(pix);
    sof       = s;
    pix_valid = v;
    if (v) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = PIX_W'(pix);
      if (m_row >= 8 && m_col >= 8) begin
        for (int i = 0; i < 9; i++)
          for (int j = 0; j < 9; j++)
            e.w[i*9+j] = img[m_row-8+i][m_col-8+j];
        e.row = m_row;
        e.col = m_col;
        e.due = cyc + 1;
        sb_q.push_back(e);
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: flags missing, unexpected, late or wrong windows.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL missing_window (%0d,%0d): got no pulse expected pulse at cycle %0d",
                 sb_q[0].row, sb_q[0].col, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      if (win_valid) begin
        pulse_cnt++;
        if (pulse_cnt == 1) begin
          first_win = window;
          first_cyc = cyc;
`ifdef LB_COORD_EN
          first_row = int'(win_row);
          first_col = int'(win_col);
`endif
        end
        last_win = window;
`ifdef LB_COORD_EN
        last_row = int'(win_row);
        last_col = int'(win_col);
`endif
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_pulse: got win_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          int bad_idx;
          mon_e   = sb_q.pop_front();
          bad_idx = -1;
          for (int i = WIN_AREA - 1; i >= 0; i--)
            if (window[i] !== mon_e.w[i]) bad_idx = i;
          if (mon_e.due != cyc) begin
            bad++;
            $display("[TB] FAIL window_timing (%0d,%0d): got cycle %0d expected cycle %0d",
                     mon_e.row, mon_e.col, cyc, mon_e.due);
          end else if (bad_idx >= 0) begin
            bad++;
            $display("[TB] FAIL window_data (%0d,%0d) idx %0d: got %0d expected %0d",
                     mon_e.row, mon_e.col, bad_idx, window[bad_idx], mon_e.w[bad_idx]);
          end
`ifdef LB_COORD_EN
          else if (int'(win_row) != mon_e.row || int'(win_col) != mon_e.col) begin
            bad++;
            $display("[TB] FAIL window_coord: got (%0d,%0d) expected (%0d,%0d)",
                     win_row, win_col, mon_e.row, mon_e.col);
          end
`endif
        end
      end
    end
  end

  function automatic int nonzeroCount();
    int n = 0;
    for (int i = 0; i < WIN_AREA; i++)
      if (window[i] !== '0) n++;
    return n;
  endfunction

  task automatic checkFrame(input string name, input int w0, input int w8, input int w72,
                            input int w80, input int last80);
    checkOutput({name, "_count"}, pulse_cnt, 16);
    checkOutput({name, "_first_w0"}, int'(first_win[0]), w0);
    checkOutput({name, "_first_w8"}, int'(first_win[8]), w8);
    checkOutput({name, "_first_w72"}, int'(first_win[72]), w72);
    checkOutput({name, "_first_w80"}, int'(first_win[80]), w80);
    checkOutput({name, "_last_w80"}, int'(last_win[80]), last80);
`ifdef LB_COORD_EN
    checkOutput({name, "_first_row"}, first_row, 8);
    checkOutput({name, "_first_col"}, first_col, 8);
    checkOutput({name, "_last_row"}, last_row, 11);
    checkOutput({name, "_last_col"}, last_col, 11);
`endif
  endtask

  initial begin
    int   c0;
    win_t snap;
    int   diffs;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", int'(win_valid), 0);
    checkOutput("reset_window", nonzeroCount(), 0);
`ifdef LB_COORD_EN
    checkOutput("reset_row", int'(win_row), 0);
    checkOutput("reset_col", int'(win_col), 0);
`endif
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 1'b0);

    // Continuous frame
    $display("[TB] continuous frame");
    pulse_cnt = 0;
    c0 = cyc;
    for (int n = 0; n < W * H; n++) applyStimulus(n % 128, n == 0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("cont", 0, 8, 96, 104, 15);
    checkOutput("cont_first_latency", first_cyc - c0, 105);

    // Same frame with an idle cycle after every pixel
    $display("[TB] idle-gapped frame");
    pulse_cnt = 0;
    for (int n = 0; n < W * H; n++) begin
      applyStimulus(n % 128, 1'b0, 1'b1);
      snap = window;
      applyStimulus($urandom_range(0, 127), 1'($urandom_range(0, 1)), 1'b0);
      diffs = 0;
      for (int i = 0; i < WIN_AREA; i++)
        if (window[i] !== snap[i]) diffs++;
      checkOutput("idle_hold", diffs, 0);
      checkOutput("idle_valid", int'(win_valid), 0);
    end
    checkFrame("idle", 0, 8, 96, 104, 15);

    // Two back-to-back frames without sof
    $display("[TB] back-to-back frames");
    pulse_cnt = 0;
    for (int n = 0; n < 2 * W * H; n++) applyStimulus((n % (W * H)) % 128, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("b2b_count", pulse_cnt, 32);
    checkOutput("b2b_last_w80", int'(last_win[80]), 15);

    // sof on the natural wrap position
    $display("[TB] sof at natural wrap");
    pulse_cnt = 0;
    for (int n = 0; n < W * H; n++) applyStimulus(n % 128, n == 0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("wrapsof", 0, 8, 96, 104, 15);

    // sof resync at (5,3); post-resync pixel k has value (63+k) mod 128
    $display("[TB] sof resync");
    pulse_cnt = 0;
    for (int n = 0; n < 63; n++) applyStimulus(n % 128, 1'b0, 1'b1);
    c0 = cyc;
    for (int k = 0; k < W * H; k++) applyStimulus((63 + k) % 128, k == 0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("resync", 63, 71, 159 % 128, 39, 78);
    checkOutput("resync_latency", first_cyc - c0, 105);

    // Reset pulsed where pixel (10,10) would be presented
    $display("[TB] mid-frame reset");
    pulse_cnt = 0;
    for (int n = 0; n < 130; n++) applyStimulus(n % 128, 1'b0, 1'b1);
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("rst_mid_valid", int'(win_valid), 0);
    checkOutput("rst_mid_window", nonzeroCount(), 0);
    checkOutput("rst_mid_prior_pulses", pulse_cnt, 9);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_window", nonzeroCount(), 0);
    m_row = 0;
    m_col = 0;
    rst_n = 1'b1;
    pulse_cnt = 0;
    c0 = cyc;
    for (int n = 0; n < W * H; n++) applyStimulus(n % 128, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    checkFrame("rstart", 0, 8, 96, 104, 15);
    checkOutput("rstart_latency", first_cyc - c0, 105);

    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
